crc_check_rx: RTL and testbench

//  Downstream stage of the CRC-5 generator. Accepts a 15-bit codeword {data[9:0], crc[4:0]},

---
 rtl/crc5_pkg.sv | 12 +
 rtl/crc5_lfsr_step.sv | 15 +
 rtl/crc_check_rx.sv | 122 ++++++++++++
 tb/tb_crc_check_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc5_pkg.sv
// Shared CRC-5 constants for the generator and checker, G(x) = x^5 + x^4 + x^2 + 1.
package crc5_pkg;

    localparam int DATA_W = 10;
    localparam int CRC_W  = 5;
    localparam int CW     = DATA_W + CRC_W;
    localparam int CNT_W  = $clog2(CW);

    // Generator polynomial with the implicit x^5 term dropped.
    localparam logic [CRC_W-1:0] POLY = 5'h15;

endpackage

// File: rtl/crc5_lfsr_step.sv
// One bit of CRC-5 polynomial division: folds a new bit into the running remainder.
module crc5_lfsr_step
    import crc5_pkg::*;
(
    input  logic [CRC_W-1:0] i_r,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_r
);

    logic w_fb;

    assign w_fb = i_r[CRC_W-1];
    assign o_r  = {i_r[CRC_W-2:0], i_bit} ^ (w_fb ? POLY : '0);

endmodule

// File: rtl/crc_check_rx.sv
// CRC-5 receive checker: divides a 15-bit codeword bit-serially, reports payload, pass flag and
// syndrome, and keeps a saturating count of failed codewords.
module crc_check_rx
    import crc5_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_codeword,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_crc_ok,
    output logic [CRC_W-1:0]     out_syndrome,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds valid and its payload steady until that edge.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_shift;
    logic [CRC_W-1:0]       r_crc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;
    logic                   r_crc_ok;
    logic [CRC_W-1:0]       r_syndrome;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic [CRC_W-1:0]       w_next_crc;
    logic [CW-1:0]          w_rot;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_err_inc;

    crc5_lfsr_step u_step (
        .i_r   (r_crc),
        .i_bit (r_shift[CW-1]),
        .o_r   (w_next_crc)
    );

    // The shift register rotates rather than shifts, so after CW rotations it holds the
    // original codeword again; w_rot is that value on the last bit.
    assign w_rot     = {r_shift[CW-2:0], r_shift[CW-1]};
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == '0);
    assign w_err_inc = w_last && (w_next_crc != '0) && (r_err_cnt != '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_crc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_crc_ok    <= 1'b0;
            r_syndrome  <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= in_codeword;
                        r_crc   <= '0;
                        r_cnt   <= CNT_W'(CW - 1);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift <= w_rot;
                    r_crc   <= w_next_crc;
                    r_cnt   <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_rot[CW-1:CRC_W];
                        r_syndrome  <= w_next_crc;
                        r_crc_ok    <= (w_next_crc == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase

            if (clr_err) begin
                r_err_cnt <= '0;
            end else if (w_err_inc) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_crc_ok   = r_crc_ok;
    assign out_syndrome = r_syndrome;
    assign err_count    = r_err_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_crc_check_rx.sv
// Directed bench for crc_check_rx: latency, good/bad codewords, backpressure, saturation, reset.
module tb_crc_check_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_codeword = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [9:0]  out_data;
    logic        out_crc_ok;
    logic [4:0]  out_syndrome;
    logic        clr_err = 1'b0;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    crc_check_rx dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_codeword  (in_codeword),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_crc_ok   (out_crc_ok),
        .out_syndrome (out_syndrome),
        .clr_err      (clr_err),
        .err_count    (err_count),
        .o_dbg_state  (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one codeword, returns once out_valid is seen; lat counts cycles after the accept.
    task automatic send_cw(input logic [14:0] cw, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_valid    = 1'b1;
        in_codeword = cw;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: out_valid=%0b required 1 (cw=%h)", out_valid, cw);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 10'h000) begin n_fail++; $display("FAIL rst_out_data: got %h expected 000", out_data); end
        n_checks++; if (out_crc_ok !== 1'b0) begin n_fail++; $display("FAIL rst_crc_ok: got %b expected 0", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h00) begin n_fail++; $display("FAIL rst_syndrome: got %h expected 00", out_syndrome); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rst_err_count: got %h expected 00", err_count); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_zero();
        int lat;
        send_cw(15'h0000, lat);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL zero_latency: got %0d expected 16", lat); end
        n_checks++; if (out_data !== 10'h000) begin n_fail++; $display("FAIL zero_data: got %h expected 000", out_data); end
        n_checks++; if (out_crc_ok !== 1'b1) begin n_fail++; $display("FAIL zero_ok: got %b expected 1", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h00) begin n_fail++; $display("FAIL zero_syndrome: got %h expected 00", out_syndrome); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_handshake: out_valid got %b expected 0", out_valid); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL zero_back_idle: state got %0d expected 0", dbg_state); end
    endtask

    task automatic test_good();
        int lat;
        send_cw(15'h0035, lat);
        n_checks++; if (out_data !== 10'h001) begin n_fail++; $display("FAIL good1_data: got %h expected 001", out_data); end
        n_checks++; if (out_crc_ok !== 1'b1) begin n_fail++; $display("FAIL good1_ok: got %b expected 1", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h00) begin n_fail++; $display("FAIL good1_syndrome: got %h expected 00", out_syndrome); end
        tick();
        send_cw(15'h005F, lat);
        n_checks++; if (out_data !== 10'h002) begin n_fail++; $display("FAIL good2_data: got %h expected 002", out_data); end
        n_checks++; if (out_crc_ok !== 1'b1) begin n_fail++; $display("FAIL good2_ok: got %b expected 1", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h00) begin n_fail++; $display("FAIL good2_syndrome: got %h expected 00", out_syndrome); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL good_err_count: got %h expected 00", err_count); end
        tick();
    endtask

    task automatic test_bad();
        int lat;
        send_cw(15'h0034, lat);
        n_checks++; if (out_data !== 10'h001) begin n_fail++; $display("FAIL bad1_data: got %h expected 001", out_data); end
        n_checks++; if (out_crc_ok !== 1'b0) begin n_fail++; $display("FAIL bad1_ok: got %b expected 0", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h01) begin n_fail++; $display("FAIL bad1_syndrome: got %h expected 01", out_syndrome); end
        n_checks++; if (err_count !== 8'h01) begin n_fail++; $display("FAIL bad1_err_count: got %h expected 01", err_count); end
        tick();
        // Payload 0 with crc 5'h15: the remainder of a degree<5 polynomial is itself.
        send_cw(15'h0015, lat);
        n_checks++; if (out_data !== 10'h000) begin n_fail++; $display("FAIL bad2_data: got %h expected 000", out_data); end
        n_checks++; if (out_crc_ok !== 1'b0) begin n_fail++; $display("FAIL bad2_ok: got %b expected 0", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h15) begin n_fail++; $display("FAIL bad2_syndrome: got %h expected 15", out_syndrome); end
        n_checks++; if (err_count !== 8'h02) begin n_fail++; $display("FAIL bad2_err_count: got %h expected 02", err_count); end
        tick();
    endtask

    task automatic test_hold();
        int lat;
        out_ready = 1'b0;
        send_cw(15'h0054, lat);
        in_valid    = 1'b1;
        in_codeword = 15'h0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (out_data !== 10'h002) begin n_fail++; $display("FAIL hold_data[%0d]: got %h expected 002", i, out_data); end
            n_checks++; if (out_syndrome !== 5'h0B) begin n_fail++; $display("FAIL hold_syndrome[%0d]: got %h expected 0b", i, out_syndrome); end
            n_checks++; if (out_crc_ok !== 1'b0) begin n_fail++; $display("FAIL hold_ok[%0d]: got %b expected 0", i, out_crc_ok); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
            n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL hold_state[%0d]: got %0d expected 2", i, dbg_state); end
        end
        n_checks++; if (err_count !== 8'h03) begin n_fail++; $display("FAIL hold_err_count: got %h expected 03", err_count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b expected 0", out_valid); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL hold_release_state: got %0d expected 0", dbg_state); end
        n_checks++; if (out_data !== 10'h002) begin n_fail++; $display("FAIL hold_kept_data: got %h expected 002", out_data); end
        n_checks++; if (out_syndrome !== 5'h0B) begin n_fail++; $display("FAIL hold_kept_syndrome: got %h expected 0b", out_syndrome); end
    endtask

    task automatic test_back_to_back();
        int acc_q[$];
        int n_bad_ok;
        n_bad_ok    = 0;
        in_codeword = 15'h0035;
        in_valid    = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (in_valid && in_ready) acc_q.push_back(c);
            if (out_valid && !out_crc_ok) n_bad_ok++;
            tick();
        end
        in_valid = 1'b0;
        repeat (20) tick();
        n_checks++; if (acc_q.size() !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", acc_q.size()); end
        if (acc_q.size() >= 3) begin
            n_checks++; if (acc_q[1] - acc_q[0] !== 17) begin n_fail++; $display("FAIL b2b_period0: got %0d expected 17", acc_q[1] - acc_q[0]); end
            n_checks++; if (acc_q[2] - acc_q[1] !== 17) begin n_fail++; $display("FAIL b2b_period1: got %0d expected 17", acc_q[2] - acc_q[1]); end
        end
        n_checks++; if (n_bad_ok !== 0) begin n_fail++; $display("FAIL b2b_ok: got %0d failing results expected 0", n_bad_ok); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL b2b_drained: state got %0d expected 0", dbg_state); end
    endtask

    task automatic test_saturate();
        int lat;
        // Counter enters at 3 from earlier failures.
        for (int i = 0; i < 300; i++) begin
            send_cw(15'h0034, lat);
            if (i == 250) begin
                n_checks++; if (err_count !== 8'hFE) begin n_fail++; $display("FAIL sat_count_254: got %h expected fe", err_count); end
            end
            tick();
        end
        n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_count: got %h expected ff", err_count); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL clr_alone: got %h expected 00", err_count); end
        send_cw(15'h0034, lat);
        tick();
        n_checks++; if (err_count !== 8'h01) begin n_fail++; $display("FAIL clr_then_err: got %h expected 01", err_count); end
        // Clear in the same cycle the failing result is registered.
        in_valid    = 1'b1;
        in_codeword = 15'h0034;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_same_valid: got %b expected 1", out_valid); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL clr_same_cycle: got %h expected 00", err_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        send_cw(15'h0054, lat);
        tick();
        n_checks++; if (err_count !== 8'h01) begin n_fail++; $display("FAIL rmid_pre_err: got %h expected 01", err_count); end
        in_codeword = 15'h0035;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rmid_in_shift: got %0d expected 1", dbg_state); end
        rst = 1'b1;
        tick();
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d expected 0", dbg_state); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rmid_err: got %h expected 00", err_count); end
        n_checks++; if (out_data !== 10'h000) begin n_fail++; $display("FAIL rmid_data: got %h expected 000", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        send_cw(15'h005F, lat);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL rmid_latency: got %0d expected 16", lat); end
        n_checks++; if (out_data !== 10'h002) begin n_fail++; $display("FAIL rmid_after_data: got %h expected 002", out_data); end
        n_checks++; if (out_crc_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_after_ok: got %b expected 1", out_crc_ok); end
        n_checks++; if (out_syndrome !== 5'h00) begin n_fail++; $display("FAIL rmid_after_syndrome: got %h expected 00", out_syndrome); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rmid_after_err: got %h expected 00", err_count); end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_good();
        test_bad();
        test_hold();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
